cpu_trace_buffer: RTL and testbench
===================================

Name: cpu_trace_buffer

Overview:
Parametrised hardware instruction-trace capture unit for the single-cycle MIPS CPU. It records (PC, instruction) pairs of retired instructions into a DEPTH-entry circular buffer. Capture runs in one-shot mode, or in triggered mode, which uses a PC-match trigger plus a post-trigger window. After capture, entries are replayed oldest-first over a valid/ready port with decoded opcode/rs/rt/sign-extended offset fields. This replaces ad-hoc cycle-by-cycle bench printing with an on-chip, depth-bounded trace usable in any CPU top.

Parameters:
PC_W, 32, width of captured program counter
DEPTH, 16, buffer entries; power of two, >= 2
POST_TRIG, 4, entries captured after (not including) the trigger entry; 0..DEPTH-1

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
arm  input  1  pulse: start capture (honoured only in IDLE)
abort  input  1  pulse: return to IDLE from any state
trig_en  input  1  0 = one-shot fill, 1 = triggered circular capture (sampled on arm)
trig_pc  input  PC_W  trigger PC (sampled on arm)
cap_valid  input  1  retired-instruction strobe
pc_in  input  PC_W  PC of retiring instruction
instr_in  input  32  instruction word
rd_start  input  1  pulse: begin readout (honoured only in DONE)
rd_ready  input  1  consumer accepts current entry
rd_valid  output  1  readout entry valid
rd_pc  output  PC_W  entry PC
rd_instr  output  32  entry instruction
rd_opcode  output  6  instr[31:26]
rd_rs  output  5  instr[25:21]
rd_rt  output  5  instr[20:16]
rd_imm  output  32  sign-extended instr[15:0]
rd_last  output  1  current entry is newest
count  output  $clog2(DEPTH)+1  valid entries held, saturates at DEPTH
overflow  output  1  at least one entry overwritten since arm
state  output  3  IDLE=0, CAPTURE=1, POST=2, DONE=3, READ=4

Behaviour:
- Reset (async, immediate): state=IDLE; wr_ptr, rd_ptr, count, post counter = 0; overflow=0; rd_valid=0; rd_last=0. Buffer contents are don't-care.
- Data outputs (rd_pc, rd_instr, decoded fields) come combinationally from the entry at rd_ptr. They are driven as 0 when state != READ.
- IDLE: on arm, clear wr_ptr/count/overflow, latch trig_en and trig_pc, then go to CAPTURE. arm outside IDLE is ignored.
- Write rule (CAPTURE, POST): on an edge with cap_valid=1, write {pc_in, instr_in} at wr_ptr. wr_ptr increments mod DEPTH. count increments up to DEPTH. If count==DEPTH before the write, set overflow (sticky until next arm).
- CAPTURE, trig_en=0: the write that makes count==DEPTH moves the state to DONE on that edge. No overflow is possible in this mode.
- CAPTURE, trig_en=1: capture is circular. A write with pc_in==trig_pc is the trigger entry. With POST_TRIG==0 the state goes to DONE. Otherwise the post counter is loaded with POST_TRIG and the state goes to POST.
- POST: each write decrements the post counter. The write that takes it to 0 moves the state to DONE. PC matches are ignored here.
- DONE: holds contents. On rd_start, rd_ptr = (wr_ptr - count) mod DEPTH, which is the oldest entry, and the state goes to READ.
- READ: rd_valid=1. An entry transfers on an edge with rd_valid&&rd_ready, and rd_ptr then increments mod DEPTH. Outputs stay stable while rd_ready=0. rd_last=1 when the entry is the count-th one. Transfer of the last entry moves the state to IDLE with rd_valid=0 on the next cycle. count=0 in DONE cannot occur.
- cap_valid is ignored in IDLE, DONE and READ.
- abort: next edge goes to IDLE and clears count/overflow. abort beats arm, rd_start and the capture write in the same cycle.
- Reset mid-operation follows the reset rule, with no partial readout resumed.

Test Plan:
- One-shot: DEPTH=16, trig_en=0, arm, then 20 strobes PC=0,4,…,76 -> DONE after PC 60; count=16, overflow=0. Readout gives PC 0..60 in order, with rd_last only on PC 60.
- Triggered wrap: trig_en=1, trig_pc=100, POST_TRIG=4, strobes PC=0,4,… -> DONE after PC 116; count=16, overflow=1. Readout gives PC 56..116, and PCs 120+ are not captured.
- Backpressure: during readout toggle rd_ready 1,0,0,1,… -> each of the 16 entries is delivered exactly once, in order, with outputs held during stalls.
- Decode: capture instr 0x8C22FFFC -> rd_opcode=0x23, rd_rs=1, rd_rt=2, rd_imm=0xFFFFFFFC. Also capture 0x20030005 -> opcode 0x08, rs=0, rt=3, imm=0x00000005.
- Abort/priority: arm and abort in the same cycle -> stays IDLE. abort after the 3rd readout beat -> IDLE next edge, rd_valid=0, count=0.
- Async reset: assert reset mid-clock during POST -> state=0, rd_valid=0, count=0 immediately without waiting for a clock edge. After release, a fresh arm behaves as in the first scenario.

Source files
------------

// File: rtl/cpu_trace_buffer_if.sv
// Control, capture and readout signals of the instruction-trace buffer.
// The master side drives arm/capture/readout requests; the slave side is the buffer.
interface cpu_trace_buffer_if #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             arm;
  logic             abort;
  logic             trig_en;
  logic [PC_W-1:0]  trig_pc;
  logic             cap_valid;
  logic [PC_W-1:0]  pc_in;
  logic [31:0]      instr_in;
  logic             rd_start;
  logic             rd_ready;
  logic             rd_valid;
  logic [PC_W-1:0]  rd_pc;
  logic [31:0]      rd_instr;
  logic [5:0]       rd_opcode;
  logic [4:0]       rd_rs;
  logic [4:0]       rd_rt;
  logic [31:0]      rd_imm;
  logic             rd_last;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [2:0]       state;

  modport master (
    output arm, abort, trig_en, trig_pc, cap_valid, pc_in, instr_in, rd_start, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_opcode, rd_rs, rd_rt, rd_imm, rd_last,
           count, overflow, state
  );

  modport slave (
    input  arm, abort, trig_en, trig_pc, cap_valid, pc_in, instr_in, rd_start, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_opcode, rd_rs, rd_rt, rd_imm, rd_last,
           count, overflow, state
  );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture unit: records retired (PC, instr) pairs in a circular
// buffer (one-shot or PC-triggered with post window) and replays them oldest-first.
module cpu_trace_buffer #(
  parameter int PC_W      = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4
) (
  input logic               clk,
  input logic               reset,
  cpu_trace_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CAPTURE = 3'd1,
    S_POST    = 3'd2,
    S_DONE    = 3'd3,
    S_READ    = 3'd4
  } state_e;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] post_q, post_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             trig_en_q, trig_en_d;
  logic [PC_W-1:0]  trig_pc_q, trig_pc_d;
  logic             we;
  logic             is_last;

  logic [PC_W-1:0]  pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];

  // The newest entry always sits just behind the write pointer.
  assign is_last = (rd_ptr_q == wr_ptr_q - PTR_W'(1));

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_d     = post_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    trig_en_d  = trig_en_q;
    trig_pc_d  = trig_pc_q;
    we         = 1'b0;
    if (bus.abort) begin
      state_d    = S_IDLE;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.arm) begin
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            trig_en_d  = bus.trig_en;
            trig_pc_d  = bus.trig_pc;
            state_d    = S_CAPTURE;
          end
        end
        S_CAPTURE, S_POST: begin
          if (bus.cap_valid) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (count_q == CNT_W'(DEPTH)) overflow_d = 1'b1;
            else                          count_d    = count_q + CNT_W'(1);
            if (state_q == S_CAPTURE) begin
              if (!trig_en_q) begin
                if (count_q == CNT_W'(DEPTH - 1)) state_d = S_DONE;
              end else if (bus.pc_in == trig_pc_q) begin
                if (POST_TRIG == 0) begin
                  state_d = S_DONE;
                end else begin
                  post_d  = PTR_W'(POST_TRIG);
                  state_d = S_POST;
                end
              end
            end else begin
              post_d = post_q - PTR_W'(1);
              if (post_q == PTR_W'(1)) state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.rd_start) begin
            // count==DEPTH truncates to 0, leaving the oldest entry at wr_ptr.
            rd_ptr_d = wr_ptr_q - count_q[PTR_W-1:0];
            state_d  = S_READ;
          end
        end
        S_READ: begin
          if (bus.rd_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (is_last) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      trig_en_q  <= 1'b0;
      trig_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_q     <= post_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      trig_en_q  <= trig_en_d;
      trig_pc_q  <= trig_pc_d;
    end
  end

  // Trace storage carries no reset; contents are only meaningful after a capture.
  always_ff @(posedge clk) begin
    if (we) begin
      pc_mem[wr_ptr_q]    <= bus.pc_in;
      instr_mem[wr_ptr_q] <= bus.instr_in;
    end
  end

  logic            reading;
  logic [PC_W-1:0] cur_pc;
  logic [31:0]     cur_instr;

  assign reading   = (state_q == S_READ);
  assign cur_pc    = reading ? pc_mem[rd_ptr_q]    : '0;
  assign cur_instr = reading ? instr_mem[rd_ptr_q] : '0;

  assign bus.rd_valid  = reading;
  assign bus.rd_last   = reading && is_last;
  assign bus.rd_pc     = cur_pc;
  assign bus.rd_instr  = cur_instr;
  assign bus.rd_opcode = cur_instr[31:26];
  assign bus.rd_rs     = cur_instr[25:21];
  assign bus.rd_rt     = cur_instr[20:16];
  assign bus.rd_imm    = sext16(cur_instr[15:0]);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: directed scenarios, a decode vector
// table, and randomized captures checked against a queue-based reference model.
module tb_cpu_trace_buffer;
  localparam int PC_W      = 32;
  localparam int DEPTH     = 16;
  localparam int POST_TRIG = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_trace_buffer_if #(.PC_W(PC_W), .DEPTH(DEPTH)) tif ();

  cpu_trace_buffer #(.PC_W(PC_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (tif.slave)
  );

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] imm;
  } dec_vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  ent_t exp_q[$];
  bit   exp_ovf;
  bit   mdone;
  int   post_left;
  bit   mte;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic arm(input bit te, input logic [PC_W-1:0] tpc);
    tif.arm = 1'b1; tif.trig_en = te; tif.trig_pc = tpc;
    @(negedge clk);
    tif.arm = 1'b0;
  endtask

  task automatic strobe(input ent_t s, input bit v);
    tif.cap_valid = v; tif.pc_in = s.pc; tif.instr_in = s.instr;
    @(negedge clk);
    tif.cap_valid = 1'b0;
  endtask

  task automatic do_abort();
    tif.abort = 1'b1;
    @(negedge clk);
    tif.abort = 1'b0;
  endtask

  // Arm, feed the stimulus, and track what the buffer should hold.
  task automatic capture(input bit te, input logic [PC_W-1:0] tpc, input ent_t stim[$],
                         input bit gaps);
    ent_t junk;
    arm(te, tpc);
    exp_q.delete(); exp_ovf = 0; mdone = 0; post_left = -1; mte = te;
    foreach (stim[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        junk.pc = tpc; junk.instr = $urandom;
        strobe(junk, 1'b0);
      end
      strobe(stim[i], 1'b1);
      if (!mdone) begin
        exp_q.push_back(stim[i]);
        if (exp_q.size() > DEPTH) begin
          void'(exp_q.pop_front());
          exp_ovf = 1;
        end
        if (!te) mdone = (exp_q.size() == DEPTH);
        else if (post_left > 0) begin
          post_left--;
          mdone = (post_left == 0);
        end else if (stim[i].pc == tpc) begin
          if (POST_TRIG == 0) mdone = 1;
          else post_left = POST_TRIG;
        end
      end
    end
  endtask

  task automatic check_capture(input string tag);
    int es;
    es = mdone ? 3 : ((mte && post_left > 0) ? 2 : 1);
    chk({tag, "_state"}, tif.state, es);
    chk({tag, "_count"}, tif.count, exp_q.size());
    chk({tag, "_ovf"}, tif.overflow, exp_ovf);
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready.
  task automatic readout(input string tag, input int mode, input int abort_after);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    ent_t e;
    tif.rd_start = 1'b1;
    @(negedge clk);
    tif.rd_start = 1'b0;
    chk({tag, "_rd_state"}, tif.state, 4);
    while (idx < exp_q.size() && cyc < 400) begin
      e = exp_q[idx];
      chk({tag, "_rd_valid"}, tif.rd_valid, 1);
      chk({tag, "_rd_pc"}, tif.rd_pc, e.pc);
      chk({tag, "_rd_instr"}, tif.rd_instr, e.instr);
      chk({tag, "_rd_op"}, tif.rd_opcode, e.instr[31:26]);
      chk({tag, "_rd_rs"}, tif.rd_rs, e.instr[25:21]);
      chk({tag, "_rd_rt"}, tif.rd_rt, e.instr[20:16]);
      chk({tag, "_rd_imm"}, tif.rd_imm, {{16{e.instr[15]}}, e.instr[15:0]});
      chk({tag, "_rd_last"}, tif.rd_last, idx == exp_q.size() - 1);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      tif.rd_ready = rdy;
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
      if (idx == abort_after) begin
        tif.rd_ready = 1'b0;
        do_abort();
        chk({tag, "_abort_state"}, tif.state, 0);
        chk({tag, "_abort_valid"}, tif.rd_valid, 0);
        chk({tag, "_abort_count"}, tif.count, 0);
        return;
      end
    end
    tif.rd_ready = 1'b0;
    chk({tag, "_drained"}, idx, exp_q.size());
    chk({tag, "_end_state"}, tif.state, 0);
    chk({tag, "_end_valid"}, tif.rd_valid, 0);
  endtask

  task automatic one_shot_scenario(input string tag, input int mode);
    ent_t s[$];
    for (int i = 0; i < 20; i++) s.push_back('{pc: PC_W'(i * 4), instr: $urandom});
    capture(1'b0, '0, s, 1'b0);
    check_capture(tag);
    chk({tag, "_newest"}, exp_q[DEPTH-1].pc, 60);
    readout(tag, mode, -1);
  endtask

  dec_vec_t dtab[6];

  initial begin
    ent_t s[$];
    reset = 1'b1;
    tif.arm = 0; tif.abort = 0; tif.trig_en = 0; tif.trig_pc = '0; tif.cap_valid = 0;
    tif.pc_in = '0; tif.instr_in = '0; tif.rd_start = 0; tif.rd_ready = 0;

    dtab[0] = '{32'h8C22FFFC, 6'h23, 5'd1,  5'd2,  32'hFFFFFFFC};
    dtab[1] = '{32'h20030005, 6'h08, 5'd0,  5'd3,  32'h00000005};
    dtab[2] = '{32'hFFFFFFFF, 6'h3F, 5'd31, 5'd31, 32'hFFFFFFFF};
    dtab[3] = '{32'h00008000, 6'h00, 5'd0,  5'd0,  32'hFFFF8000};
    dtab[4] = '{32'h00007FFF, 6'h00, 5'd0,  5'd0,  32'h00007FFF};
    dtab[5] = '{32'hAFBF0010, 6'h2B, 5'd29, 5'd31, 32'h00000010};

    @(negedge clk); @(negedge clk);
    chk("rst_state", tif.state, 0);
    chk("rst_valid", tif.rd_valid, 0);
    chk("rst_last", tif.rd_last, 0);
    chk("rst_count", tif.count, 0);
    chk("rst_ovf", tif.overflow, 0);
    chk("rst_pc", tif.rd_pc, 0);
    reset = 1'b0;
    @(negedge clk);

    one_shot_scenario("oneshot", 0);

    // Triggered wrap: trigger at PC 100, keep strobing well past the window.
    s.delete();
    for (int i = 0; i < 40; i++) s.push_back('{pc: PC_W'(i * 4), instr: $urandom});
    capture(1'b1, 100, s, 1'b0);
    check_capture("trig");
    chk("trig_oldest", exp_q[0].pc, 56);
    chk("trig_newest", exp_q[DEPTH-1].pc, 116);
    readout("trig", 0, -1);

    // Backpressure on the triggered capture pattern.
    capture(1'b1, 100, s, 1'b0);
    check_capture("bp");
    readout("bp", 1, -1);

    // Decode table: vector is the oldest entry of a one-shot fill.
    for (int v = 0; v < 6; v++) begin
      s.delete();
      s.push_back('{pc: 32'h400, instr: dtab[v].instr});
      for (int i = 1; i < DEPTH; i++) s.push_back('{pc: PC_W'(32'h400 + i * 4), instr: $urandom});
      capture(1'b0, '0, s, 1'b0);
      tif.rd_start = 1'b1;
      @(negedge clk);
      tif.rd_start = 1'b0;
      chk($sformatf("dec%0d_instr", v), tif.rd_instr, dtab[v].instr);
      chk($sformatf("dec%0d_op", v), tif.rd_opcode, dtab[v].op);
      chk($sformatf("dec%0d_rs", v), tif.rd_rs, dtab[v].rs);
      chk($sformatf("dec%0d_rt", v), tif.rd_rt, dtab[v].rt);
      chk($sformatf("dec%0d_imm", v), tif.rd_imm, dtab[v].imm);
      do_abort();
    end

    // arm and abort together: abort wins.
    tif.arm = 1'b1; tif.abort = 1'b1;
    @(negedge clk);
    tif.arm = 1'b0; tif.abort = 1'b0;
    chk("armabort_state", tif.state, 0);

    // Abort after the third readout beat.
    s.delete();
    for (int i = 0; i < DEPTH; i++) s.push_back('{pc: PC_W'(i * 4), instr: $urandom});
    capture(1'b0, '0, s, 1'b0);
    check_capture("abrt");
    readout("abrt", 0, 3);

    // Asynchronous reset while in the post-trigger window.
    s.delete();
    for (int i = 0; i < 4; i++) s.push_back('{pc: PC_W'(i * 4), instr: $urandom});
    capture(1'b1, 8, s, 1'b0);
    check_capture("post");
    #2 reset = 1'b1;
    #1;
    chk("areset_state", tif.state, 0);
    chk("areset_valid", tif.rd_valid, 0);
    chk("areset_count", tif.count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    one_shot_scenario("rearm", 2);

    // Randomized captures with idle gaps and random readout backpressure.
    for (int r = 0; r < 12; r++) begin
      bit te;
      logic [PC_W-1:0] tpc;
      int n;
      te  = 1'($urandom_range(0, 1));
      tpc = PC_W'(4 * $urandom_range(0, 15));
      n   = $urandom_range(5, 40);
      s.delete();
      for (int i = 0; i < n; i++)
        s.push_back('{pc: PC_W'(4 * $urandom_range(0, 15)), instr: $urandom});
      capture(te, tpc, s, 1'b1);
      check_capture($sformatf("rnd%0d", r));
      if (mdone) readout($sformatf("rnd%0d", r), 2, -1);
      else begin
        do_abort();
        chk($sformatf("rnd%0d_abort_state", r), tif.state, 0);
        chk($sformatf("rnd%0d_abort_count", r), tif.count, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
